// File: rtl/stim_sequencer_if.sv
// ----------------------------------------------------------------------------
// stim_sequencer_if
//   Bundles the control inputs and stimulus outputs of stim_sequencer.
//   master : the controller that requests sequences and consumes stimulus
//   slave  : the sequencer itself
//
//   start      master->slave  begin a sequence (honoured in IDLE only)
//   abort      master->slave  terminate the current sequence
//   mode       master->slave  00 thermometer, 01 walking-one, 10 binary, 11 = 00
//   step_len   master->slave  clock cycles per step (0 behaves as 1)
//   stim       slave->master  pattern for the `test` inputs a..i (bit 0 = a)
//   stim_valid slave->master  one-cycle strobe when stim takes a new step value
//   step_idx   slave->master  current step number, 0 = initial all-zero step
//   busy       slave->master  sequence in progress
//   done       slave->master  one-cycle pulse on normal completion
// ----------------------------------------------------------------------------
interface stim_sequencer_if #(
    parameter int N_IN   = 9,
    parameter int STEP_W = 16
);
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [STEP_W-1:0] step_len;
    logic [N_IN-1:0]   stim;
    logic              stim_valid;
    logic [N_IN-1:0]   step_idx;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, mode, step_len,
        input  stim, stim_valid, step_idx, busy, done
    );

    modport slave (
        input  start, abort, mode, step_len,
        output stim, stim_valid, step_idx, busy, done
    );
endinterface

// File: rtl/stim_sequencer.sv
// ----------------------------------------------------------------------------
// stim_sequencer
//   Clocked, restartable stimulus generator for the combinational `test`
//   block. Each sequence starts with an all-zero step and then walks through
//   a thermometer, walking-one or binary-count pattern, holding every step
//   for a latched number of cycles. All outputs are registered.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    stim_sequencer_if.slave (start/abort/mode/step_len in,
//          stim/stim_valid/step_idx/busy/done out)
// ----------------------------------------------------------------------------
module stim_sequencer #(
    parameter int N_IN   = 9,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    stim_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0]        MODE_THERM = 2'b00;
    localparam logic [1:0]        MODE_WALK  = 2'b01;
    localparam logic [1:0]        MODE_BIN   = 2'b10;
    localparam logic [N_IN-1:0]   IDX_ONE    = N_IN'(1);
    localparam logic [N_IN:0]     THERM_ONE  = (N_IN+1)'(1);
    localparam logic [STEP_W-1:0] CNT_ONE    = STEP_W'(1);
    // Thermometer and walking-one run N_IN steps; binary runs 2^N_IN - 1.
    localparam logic [N_IN-1:0]   LAST_SHORT = N_IN'(N_IN);
    localparam logic [N_IN-1:0]   LAST_BIN   = {N_IN{1'b1}};

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [STEP_W-1:0] len_q, len_d;
    logic [N_IN-1:0]   last_idx;

    // Pattern for step k >= 1 of the latched mode.
    function automatic logic [N_IN-1:0] pattern(input logic [1:0]      m,
                                                input logic [N_IN-1:0] k);
        logic [N_IN:0] therm;
        // One extra bit so that k = N_IN yields all ones after the subtract.
        therm = (THERM_ONE << k) - THERM_ONE;
        case (m)
            MODE_WALK: pattern = IDX_ONE << (k - IDX_ONE);
            MODE_BIN:  pattern = k;
            default:   pattern = therm[N_IN-1:0];
        endcase
    endfunction

    assign last_idx = (mode_q == MODE_BIN) ? LAST_BIN : LAST_SHORT;

    always_comb begin
        // NOTE: every next-state value is defaulted first so that no branch
        // leaves one unassigned; that is what keeps this block latch-free.
        state_d = state_q;
        stim_d  = stim_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        len_d   = len_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort beats a simultaneous start.
                if (bus.start && !bus.abort) begin
                    state_d = S_RUN;
                    mode_d  = (bus.mode == 2'b11) ? MODE_THERM : bus.mode;
                    len_d   = (bus.step_len == '0) ? CNT_ONE : bus.step_len;
                    stim_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            S_RUN: begin
                busy_d = 1'b1;
                if (bus.abort) begin
                    state_d = S_IDLE;
                    stim_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == len_q - CNT_ONE) begin
                    cnt_d = '0;
                    if (idx_q == last_idx) begin
                        // Last step has been held for a full step length.
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        stim_d  = pattern(mode_q, idx_q + IDX_ONE);
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= MODE_THERM;
            len_q   <= CNT_ONE;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
        end
    end

    assign bus.stim       = stim_q;
    assign bus.stim_valid = valid_q;
    assign bus.step_idx   = idx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
